// File: rtl/axi_lite_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : axi_lite_master
//  Description : Single-outstanding AXI4-Lite initiator. Bridges a simple
//                command/response port onto AXI4-Lite read/write channels,
//                with an optional response timeout against hung slaves.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_master #(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    // AXI4-Lite write address / data / response
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    // AXI4-Lite read address / data
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_WR_REQ  = 3'd1;
    localparam logic [2:0] c_S_WR_RESP = 3'd2;
    localparam logic [2:0] c_S_RD_REQ  = 3'd3;
    localparam logic [2:0] c_S_RD_RESP = 3'd4;
    localparam logic [2:0] c_S_RSP     = 3'd5;

    localparam logic [1:0] c_RESP_TIMEOUT = 2'b11;

    // Counter must hold TIMEOUT_CYCLES itself; expiry fires on the cycle the
    // counter would reach it, i.e. after TIMEOUT_CYCLES busy cycles.
    localparam bit                 c_TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam int                 c_CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic [31:0]           r_rsp_rdata;
    logic [1:0]            r_rsp_resp;
    logic                  r_rsp_timeout;

    logic w_accept;
    logic w_busy;
    logic w_expire;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_b_hs;
    logic w_r_hs;
    logic w_aw_fin;
    logic w_w_fin;
    logic w_take_timeout;

    assign w_accept = cmd_valid && (r_state == c_S_IDLE);
    assign w_busy   = (r_state == c_S_WR_REQ) || (r_state == c_S_WR_RESP) ||
                      (r_state == c_S_RD_REQ) || (r_state == c_S_RD_RESP);
    assign w_expire = c_TO_EN && w_busy && (r_cnt >= c_CNT_LAST);

    assign w_aw_hs  = m_axi_awvalid && m_axi_awready;
    assign w_w_hs   = m_axi_wvalid  && m_axi_wready;
    assign w_ar_hs  = m_axi_arvalid && m_axi_arready;
    assign w_b_hs   = m_axi_bready  && m_axi_bvalid;
    assign w_r_hs   = m_axi_rready  && m_axi_rvalid;

    assign w_aw_fin = r_aw_done || w_aw_hs;
    assign w_w_fin  = r_w_done  || w_w_hs;

    // A handshake landing in the expiry cycle takes priority over the timeout.
    assign w_take_timeout = w_expire && (w_next_state == c_S_RSP) && !w_b_hs && !w_r_hs;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; handshakes are checked before expiry.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (cmd_valid) begin
                    w_next_state = cmd_write ? c_S_WR_REQ : c_S_RD_REQ;
                end
            end
            c_S_WR_REQ: begin
                if (w_aw_fin && w_w_fin) begin
                    w_next_state = c_S_WR_RESP;
                end else if (w_expire) begin
                    w_next_state = c_S_RSP;
                end
            end
            c_S_WR_RESP: begin
                if (w_b_hs || w_expire) begin
                    w_next_state = c_S_RSP;
                end
            end
            c_S_RD_REQ: begin
                if (w_ar_hs) begin
                    w_next_state = c_S_RD_RESP;
                end else if (w_expire) begin
                    w_next_state = c_S_RSP;
                end
            end
            c_S_RD_RESP: begin
                if (w_r_hs || w_expire) begin
                    w_next_state = c_S_RSP;
                end
            end
            c_S_RSP: begin
                if (rsp_ready) begin
                    w_next_state = c_S_IDLE;
                end
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; AW/W valids drop individually once done.
    always_comb begin
        cmd_ready     = (r_state == c_S_IDLE);
        m_axi_awvalid = (r_state == c_S_WR_REQ) && !r_aw_done;
        m_axi_wvalid  = (r_state == c_S_WR_REQ) && !r_w_done;
        m_axi_bready  = (r_state == c_S_WR_RESP);
        m_axi_arvalid = (r_state == c_S_RD_REQ);
        m_axi_rready  = (r_state == c_S_RD_RESP);
        rsp_valid     = (r_state == c_S_RSP);
    end

    // Timeout counter and per-channel write completion flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (c_TO_EN && w_busy) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
        end
    end

    // Request payload capture and response formation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= '0;
            r_rsp_timeout <= 1'b0;
        end else if (w_accept) begin
            r_addr        <= cmd_addr;
            r_wdata       <= cmd_wdata;
            r_wstrb       <= cmd_wstrb;
            r_rsp_timeout <= 1'b0;
        end else if ((r_state == c_S_WR_RESP) && w_b_hs) begin
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= m_axi_bresp;
            r_rsp_timeout <= 1'b0;
        end else if ((r_state == c_S_RD_RESP) && w_r_hs) begin
            r_rsp_rdata   <= m_axi_rdata;
            r_rsp_resp    <= m_axi_rresp;
            r_rsp_timeout <= 1'b0;
        end else if (w_take_timeout) begin
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= c_RESP_TIMEOUT;
            r_rsp_timeout <= 1'b1;
        end
    end

    assign m_axi_awaddr = r_addr;
    assign m_axi_araddr = r_addr;
    assign m_axi_wdata  = r_wdata;
    assign m_axi_wstrb  = r_wstrb;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_resp     = r_rsp_resp;
    assign rsp_timeout  = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_master
//  Description : Directed self-checking bench for axi_lite_master with a
//                configurable AXI4-Lite slave model and response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master;

    localparam int c_AW = 12;
    localparam int c_TO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [c_AW-1:0] cmd_addr;
    logic [31:0]     cmd_wdata;
    logic [3:0]      cmd_wstrb;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            rsp_timeout;
    logic [c_AW-1:0] m_axi_awaddr;
    logic            m_axi_awvalid;
    logic            m_axi_awready;
    logic [31:0]     m_axi_wdata;
    logic [3:0]      m_axi_wstrb;
    logic            m_axi_wvalid;
    logic            m_axi_wready;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid;
    logic            m_axi_bready;
    logic [c_AW-1:0] m_axi_araddr;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [31:0]     m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rvalid;
    logic            m_axi_rready;

    always #5 clk = ~clk;

    axi_lite_master #(
        .ADDR_WIDTH     (c_AW),
        .TIMEOUT_CYCLES (c_TO)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    // ---------------- slave model knobs (driven by the stimulus) -----------
    int          s_aw_delay = 0;
    int          s_w_delay  = 0;
    int          s_ar_delay = 0;
    logic [1:0]  s_bresp    = 2'b00;
    logic [1:0]  s_rresp    = 2'b00;
    logic [31:0] s_rdata    = 32'h0;
    logic        s_b_block  = 1'b0;
    logic        s_r_enable = 1'b1;

    // ---------------- slave model state and bus monitor --------------------
    int          aw_cnt, w_cnt, ar_cnt;
    logic        aw_got, w_got, b_pend, r_pend;
    int          n_aw, n_w, n_ar, n_b, n_r, aw_hi, w_hi;
    logic [c_AW-1:0] last_awaddr, last_araddr;
    logic [31:0] last_wdata;
    logic [3:0]  last_wstrb;

    logic aw_now, w_now, ar_now;
    assign aw_now = m_axi_awvalid && m_axi_awready;
    assign w_now  = m_axi_wvalid  && m_axi_wready;
    assign ar_now = m_axi_arvalid && m_axi_arready;

    assign m_axi_awready = m_axi_awvalid && (aw_cnt >= s_aw_delay);
    assign m_axi_wready  = m_axi_wvalid  && (w_cnt  >= s_w_delay);
    assign m_axi_arready = m_axi_arvalid && (ar_cnt >= s_ar_delay);
    assign m_axi_bvalid  = b_pend && !s_b_block;
    assign m_axi_bresp   = s_bresp;
    assign m_axi_rvalid  = r_pend && s_r_enable;
    assign m_axi_rdata   = s_rdata;
    assign m_axi_rresp   = s_rresp;

    always @(posedge clk) begin
        if (reset) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_axi_wvalid  && !m_axi_wready)  ? w_cnt  + 1 : 0;
            ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
            if ((aw_now || w_now) && (aw_got || aw_now) && (w_got || w_now)) begin
                b_pend <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (aw_now) aw_got <= 1'b1;
                if (w_now)  w_got  <= 1'b1;
                if (m_axi_bvalid && m_axi_bready) b_pend <= 1'b0;
            end
            if (ar_now) r_pend <= 1'b1;
            else if (m_axi_rvalid && m_axi_rready) r_pend <= 1'b0;

            if (aw_now) begin n_aw <= n_aw + 1; last_awaddr <= m_axi_awaddr; end
            if (w_now)  begin n_w <= n_w + 1; last_wdata <= m_axi_wdata; last_wstrb <= m_axi_wstrb; end
            if (ar_now) begin n_ar <= n_ar + 1; last_araddr <= m_axi_araddr; end
            if (m_axi_bvalid && m_axi_bready) n_b <= n_b + 1;
            if (m_axi_rvalid && m_axi_rready) n_r <= n_r + 1;
            if (m_axi_awvalid) aw_hi <= aw_hi + 1;
            if (m_axi_wvalid)  w_hi  <= w_hi + 1;
        end
    end

    initial begin
        n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; n_r = 0; aw_hi = 0; w_hi = 0;
        last_awaddr = '0; last_araddr = '0; last_wdata = '0; last_wstrb = '0;
    end

    // ---------------- scoreboard and checking ------------------------------
    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [c_AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] e_rd, input logic [1:0] e_resp,
                         input logic e_to);
        exp_t e;
        int   n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_before_issue", cmd_ready, 1);
        e.rdata = e_rd; e.resp = e_resp; e.to = e_to;
        sb.push_back(e);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    endtask

    // Called one cycle after accept; measures accept-to-rsp_valid latency and
    // compares the response against the oldest scoreboard entry.
    task automatic wait_rsp(input string tag, input int exp_lat);
        exp_t e;
        int   lat;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_rsp_valid"}, rsp_valid, 1);
        chk({tag, "_latency"}, lat, exp_lat);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_scoreboard: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rdata"}, rsp_rdata, e.rdata);
            chk({tag, "_resp"}, rsp_resp, e.resp);
            chk({tag, "_timeout"}, rsp_timeout, e.to);
        end
    endtask

    task automatic consume(input string tag, input int hold);
        logic [1:0]  r0;
        logic [31:0] d0;
        logic        ok;
        r0 = rsp_resp; d0 = rsp_rdata; ok = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_resp !== r0 || rsp_rdata !== d0 || cmd_ready !== 1'b0) ok = 1'b0;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, ok, 1);
        rsp_ready = 1'b1;
        chk({tag, "_cmd_ready_in_rsp"}, cmd_ready, 0);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_after"}, rsp_valid, 0);
        chk({tag, "_cmd_ready_after"}, cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    // ---------------- directed stimulus ------------------------------------
    initial begin
        int b0, aw0, w0, r0, awh0, wh0, ar0, n;
        logic seen;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 0);
        chk("rst_readies", {m_axi_bready, m_axi_rready}, 0);
        chk("rst_awaddr", m_axi_awaddr, 0);
        chk("rst_wdata", m_axi_wdata, 0);
        chk("rst_wstrb", m_axi_wstrb, 0);
        chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
        reset = 1'b0;
        @(negedge clk);

        // zero-wait write
        aw0 = n_aw; w0 = n_w; b0 = n_b;
        issue(1'b1, 12'h008, 32'h0000_00A5, 4'hF, 32'h0, 2'b00, 1'b0);
        wait_rsp("wr0", 3);
        chk("wr0_n_aw", n_aw - aw0, 1);
        chk("wr0_n_w", n_w - w0, 1);
        chk("wr0_n_b", n_b - b0, 1);
        chk("wr0_awaddr", last_awaddr, 12'h008);
        chk("wr0_wdata", last_wdata, 32'h0000_00A5);
        chk("wr0_wstrb", last_wstrb, 4'hF);
        consume("wr0", 0);

        // zero-wait read
        ar0 = n_ar;
        s_rdata = 32'h1234_5678;
        issue(1'b0, 12'h00C, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 1'b0);
        wait_rsp("rd0", 3);
        chk("rd0_n_ar", n_ar - ar0, 1);
        chk("rd0_araddr", last_araddr, 12'h00C);
        consume("rd0", 0);

        // skewed AW/W: awready lags 4 cycles
        s_aw_delay = 4;
        aw0 = n_aw; w0 = n_w; b0 = n_b; awh0 = aw_hi; wh0 = w_hi;
        issue(1'b1, 12'h104, 32'hDEAD_BEEF, 4'h3, 32'h0, 2'b00, 1'b0);
        wait_rsp("skew", 7);
        chk("skew_aw_hi_cycles", aw_hi - awh0, 5);
        chk("skew_w_hi_cycles", w_hi - wh0, 1);
        chk("skew_n_aw", n_aw - aw0, 1);
        chk("skew_n_w", n_w - w0, 1);
        chk("skew_n_b", n_b - b0, 1);
        consume("skew", 0);
        s_aw_delay = 0;

        // SLVERR write with response back-pressure
        s_bresp = 2'b10;
        issue(1'b1, 12'h200, 32'h0000_0001, 4'h1, 32'h0, 2'b10, 1'b0);
        wait_rsp("err", 3);
        consume("err", 6);
        s_bresp = 2'b00;

        // read timeout: slave never returns R
        s_r_enable = 1'b0;
        r0 = n_r;
        issue(1'b0, 12'h010, 32'h0, 4'h0, 32'h0, 2'b11, 1'b1);
        wait_rsp("to", c_TO + 1);
        chk("to_rready_dropped", {m_axi_rready, m_axi_arvalid}, 0);
        // late R beat while in RSP must be ignored
        s_r_enable = 1'b1;
        s_rdata = 32'h5555_AAAA;
        consume("to", 2);
        chk("to_late_r_ignored", n_r - r0, 0);

        // following read to a live slave completes normally
        s_rdata = 32'hCAFE_F00D;
        issue(1'b0, 12'h014, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 1'b0);
        wait_rsp("rd1", 3);
        chk("rd1_araddr", last_araddr, 12'h014);
        consume("rd1", 0);

        // reset asserted while waiting in WR_RESP
        s_b_block = 1'b1;
        b0 = n_b;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h300; cmd_wdata = 32'h77; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!m_axi_bready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_in_wr_resp", m_axi_bready, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
        chk("rstmid_readies", {m_axi_bready, m_axi_rready}, 0);
        chk("rstmid_rsp_valid", rsp_valid, 0);
        chk("rstmid_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        s_b_block = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("rstmid_no_response", seen, 0);
        chk("rstmid_no_b", n_b - b0, 0);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- AXI4-Lite initiator. Converts a simple single-outstanding command/response interface into AXI4-Lite read and write transactions.
- Drives the peripheral slaves of the SoC, such as the I2C, GPIO and UART register blocks.
- Serves as the bus-side bridge for CPU-native or DMA-style request ports.
- Supports one transaction in flight at a time, with an optional response timeout so that a hung slave cannot lock the requester.

Parameters:
- ADDR_WIDTH, 12, width of AXI address and cmd_addr.
- TIMEOUT_CYCLES, 256, cycles allowed from command accept to B/R handshake; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  AXI resp (00 OKAY, 10 SLVERR, 11 DECERR); 11 also signals timeout.
- rsp_timeout  out  1  1 if the response was produced by timeout.
- m_axi_awaddr  out  ADDR_WIDTH  write address.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_wdata  out  32  write data.
- m_axi_wstrb  out  4  write strobes.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_araddr  out  ADDR_WIDTH  read address.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.

Behaviour:
- Reset: state IDLE.
  - All valids and readies low except cmd_ready = 1.
  - Address, data, strobe, rsp_rdata and rsp_resp = 0.
  - rsp_timeout = 0, timeout counter = 0.
  - Reset mid-transaction aborts it immediately; no response is emitted.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready = 1.
  - On accept, register addr, wdata and wstrb into the m_axi outputs and clear the counter.
  - cmd_write = 1: next state WR_REQ with awvalid = wvalid = 1.
  - cmd_write = 0: next state RD_REQ with arvalid = 1.
  - cmd_ready = 0 in all other states.
- WR_REQ:
  - awvalid and wvalid are held independently.
  - Each one drops the cycle after its own handshake (valid & ready sampled high).
  - AW and W may complete in the same cycle or in either order.
  - Once both are done, go to WR_RESP with bready = 1.
  - Valids never drop before their handshake, except on timeout or reset.
- WR_RESP:
  - bready = 1.
  - On bvalid: capture bresp into rsp_resp, set rsp_rdata = 0, drop bready, go to RSP.
- RD_REQ:
  - arvalid held until arready.
  - Then go to RD_RESP with rready = 1.
- RD_RESP:
  - rready = 1.
  - On rvalid: capture rdata and rresp, drop rready, go to RSP.
  - Also accept an R beat arriving in the same cycle as the AR handshake's successor, i.e. rvalid may be sampled in the first RD_RESP cycle.
- RSP:
  - rsp_valid = 1; hold rsp_* stable until rsp_ready.
  - On rsp_ready: rsp_valid = 0, return to IDLE.
  - cmd_ready rises in the IDLE cycle after, so there are no back-to-back accepts in the RSP exit cycle.
- Timing:
  - Minimum latency, cmd accept to rsp_valid, with zero-wait slave: write 3 cycles, read 3 cycles.
  - A slave whose ready lags its valid by one cycle adds one cycle per channel.
- Timeout (TIMEOUT_CYCLES != 0):
  - The counter increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When it reaches TIMEOUT_CYCLES, drop all m_axi valids and readies and go to RSP.
  - Response is rsp_resp = 11, rsp_timeout = 1, rsp_rdata = 0.
  - rsp_timeout clears on the next accepted command.
  - A handshake in the same cycle as expiry wins: a normal response is produced.
- Late responses: a B/R beat arriving after a timeout while the block is in RSP or IDLE is ignored, because bready and rready are low.

Test Plan:
- Write, zero-wait slave: cmd write addr 0x008, wdata 0x000000A5, wstrb 0xF -> one AW and one W handshake with awaddr = 0x008; bresp 00; rsp_valid 3 cycles after accept with rsp_resp = 00, rsp_rdata = 0.
- Read: cmd read addr 0x00C, slave returns 0x12345678 with rresp 00 -> one AR handshake with araddr = 0x00C; rsp_rdata = 0x12345678, rsp_resp = 00.
- Skewed AW/W: awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle; awvalid held 5 cycles; exactly one B accepted; rsp_resp = 00.
- Error and back-pressure: slave bresp = 10, rsp_ready held low for 6 cycles -> rsp_resp = 10 stable for 6 cycles; cmd_ready stays 0 until the IDLE cycle after rsp_ready.
- Timeout: TIMEOUT_CYCLES = 8, slave never asserts rvalid -> after 8 cycles rready drops; rsp_resp = 11, rsp_timeout = 1; a following read to a live slave completes normally with rsp_timeout = 0.
- Reset mid-transaction: reset asserted in WR_RESP -> next cycle all m_axi valids and readies are 0, rsp_valid = 0, cmd_ready = 1; no response is emitted.
